randomness_scheduler: RTL

Distributes fresh mask randomness from a single PRNG stream to up to NUM_CONSUMERS masked consumers, e.g. the share_zero stages of the S-box pipelines. Each random word is sized for one zero-sharing refresh. Incoming words are buffered in a small FIFO. Words go to requesting consumers by registered round-robin arbitration. No word is ever delivered twice or to two consumers, so mask freshness is preserved across the whole design.

---
 rtl/randomness_scheduler.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/randomness_scheduler.sv
// randomness_scheduler: buffers PRNG words in a small FIFO and hands each
// word to exactly one requesting consumer using registered round-robin
// arbitration. No word is ever delivered twice.
//
// Handshakes:
// - PRNG side uses strict valid/ready. A word transfers on a rising edge when
//   in_prng_valid && out_prng_ready. Ready depends only on registered count.
// - Consumer side is request/grant with no back-pressure. A grant bit seen in
//   a cycle means out_random belongs to that consumer in that same cycle, and
//   the consumer must take it.

package aes128_package;
  // Zero-sharing of n shares needs n-1 fresh elements; the last share is
  // the XOR of the others.
  function automatic int num_share_0(input int num_shares);
    return num_shares - 1;
  endfunction
endpackage

module randomness_scheduler
  import aes128_package::*;
#(
  parameter int NUM_SHARES    = 2,
  parameter int BIT_WIDTH     = 2,
  parameter int NUM_CONSUMERS = 4,
  parameter int FIFO_DEPTH    = 4,
  localparam int RAND_WIDTH   = num_share_0(NUM_SHARES) * BIT_WIDTH,
  localparam int FW           = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                     in_clock,
  input  logic                     in_reset,
  input  logic [RAND_WIDTH-1:0]    in_prng_data,
  input  logic                     in_prng_valid,
  output logic                     out_prng_ready,
  input  logic [NUM_CONSUMERS-1:0] in_request,
  output logic [NUM_CONSUMERS-1:0] out_grant,
  output logic [RAND_WIDTH-1:0]    out_random,
  output logic [FW-1:0]            out_fill,
  output logic                     out_starved
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  // Reject unsupported configurations at elaboration time.
  if (NUM_SHARES < 2 || NUM_SHARES > 5) begin : g_bad_shares
    $error("randomness_scheduler: NUM_SHARES must be 2..5");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
      ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("randomness_scheduler: FIFO_DEPTH must be a power of two in 2..16");
  end
  if (NUM_CONSUMERS < 1 || NUM_CONSUMERS > 8) begin : g_bad_consumers
    $error("randomness_scheduler: NUM_CONSUMERS must be 1..8");
  end

  logic [RAND_WIDTH-1:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]            count_q, count_d;
  logic [CW-1:0]            last_q, last_d;
  logic [NUM_CONSUMERS-1:0] grant_q, grant_d;
  logic [RAND_WIDTH-1:0]    random_q, random_d;
  logic                     starved_q, starved_d;

  logic          push;
  logic          pop;
  logic          win_found;
  logic [CW-1:0] win_idx;
  logic [CW-1:0] cand;

  assign out_prng_ready = (count_q != FW'(FIFO_DEPTH));
  assign out_fill       = count_q;
  assign out_grant      = grant_q;
  assign out_random     = random_q;
  assign out_starved    = starved_q;

  // Transfers are judged against the FIFO state at the start of the cycle, so
  // a word pushed this cycle cannot be popped until the next one.
  assign push = in_prng_valid && out_prng_ready;
  assign pop  = (count_q != '0) && (in_request != '0);

  // Round-robin: the first requester strictly after last_q, in cyclic order.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_q;
    cand      = '0;
    for (int k = 1; k <= NUM_CONSUMERS; k++) begin
      cand = CW'((int'(last_q) + k) % NUM_CONSUMERS);
      if (!win_found && in_request[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state logic for pointers, occupancy and the registered grant outputs.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    last_d    = last_q;
    grant_d   = '0;
    random_d  = '0;
    starved_d = (in_request != '0) && (count_q == '0);

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d         = rd_ptr_q + PW'(1);
      last_d           = win_idx;
      grant_d[win_idx] = 1'b1;
      random_d         = mem_q[rd_ptr_q];
    end

    case ({push, pop})
      2'b10:   count_d = count_q + FW'(1);
      2'b01:   count_d = count_q - FW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control and output registers; reset discards all buffered words.
  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      last_q    <= CW'(NUM_CONSUMERS - 1);
      grant_q   <= '0;
      random_q  <= '0;
      starved_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      random_q  <= random_d;
      starved_q <= starved_d;
    end
  end

  // Storage is not reset; only entries between the pointers are ever read.
  always_ff @(posedge in_clock) begin
    if (!in_reset && push) begin
      mem_q[wr_ptr_q] <= in_prng_data;
    end
  end

endmodule
